// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Optional build macro: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Address width for a register count; at least one bit.
  function automatic int calc_aw(input int nregs);
    int aw;
    aw = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < nregs) aw = i + 1;
    end
    return aw;
  endfunction

  localparam int AW_DEF = calc_aw(NREGS_DEF);

  // One write port: enable, target register, payload (default geometry).
  typedef struct packed {
    logic                en;
    logic [AW_DEF-1:0]   addr;
    logic [XLEN_DEF-1:0] data;
  } wr_port_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer scoreboard: one busy bit per register.
// Set by sb_set, cleared by any write to the register; set wins when both
// hit the same register in one cycle. Register 0 is never busy.
// Optional build macro: REGFILE_BYPASS_EN (per-port busy reflects this
// cycle's write/set instead of the registered bit).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = calc_aw(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr,
  input  logic [1:0]        wr_en,
  input  logic [2*AW-1:0]   wr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NREGS-1:0]  busy,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW-1:0]    wa0;
  logic [AW-1:0]    wa1;

  assign wa0  = wr_addr[AW-1:0];
  assign wa1  = wr_addr[2*AW-1:AW];
  assign busy = busy_q;

  // Next busy vector: clear on write, then set on issue, x0 forced clear.
  always_comb begin
    busy_d = busy_q;
    for (int n = 1; n < NREGS; n++) begin
      if ((wr_en[0] && wa0 == AW'(n)) || (wr_en[1] && wa1 == AW'(n)))
        busy_d[n] = 1'b0;
      if (sb_set && sb_addr == AW'(n))
        busy_d[n] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy register; asynchronously cleared while reset is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  // Per-read-port busy lookup.
  always_comb begin
    logic [AW-1:0] ra;
    ra      = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      ra         = rd_addr[k*AW +: AW];
      rd_busy[k] = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (rst && ra != '0 &&
          ((wr_en[0] && wa0 == ra) || (wr_en[1] && wa1 == ra)))
        rd_busy[k] = sb_set && (sb_addr == ra);
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports with registered
// copies, two write ports (port 1 wins on a shared address), register 0
// hard-wired to zero, plus a pending-producer scoreboard.
// Optional build macro: REGFILE_BYPASS_EN (same-cycle write data forwarded
// to the read ports; register 0 is never forwarded).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD*calc_aw(NREGS)-1:0] rd_addr_i,
  output logic [NRD*XLEN-1:0]    rd_data_o,
  output logic [NRD*XLEN-1:0]    rd_data_q_o,
  output logic [NRD-1:0]         rd_busy_o,
  input  logic [1:0]             wr_en_i,
  input  logic [2*calc_aw(NREGS)-1:0] wr_addr_i,
  input  logic [2*XLEN-1:0]      wr_data_i,
  input  logic                   sb_set_i,
  input  logic [calc_aw(NREGS)-1:0] sb_addr_i,
  output logic [NREGS-1:0]       busy_o
);

  localparam int AW = calc_aw(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [AW-1:0]   wa0;
  logic [AW-1:0]   wa1;
  logic [XLEN-1:0] wd0;
  logic [XLEN-1:0] wd1;

  assign wa0 = wr_addr_i[AW-1:0];
  assign wa1 = wr_addr_i[2*AW-1:AW];
  assign wd0 = wr_data_i[XLEN-1:0];
  assign wd1 = wr_data_i[2*XLEN-1:XLEN];

  // Register storage; x0 is only ever reset, port 1 overrides port 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NREGS; n++) regs_q[n] <= '0;
    end else begin
      for (int n = 1; n < NREGS; n++) begin
        if (wr_en_i[1] && wa1 == AW'(n))      regs_q[n] <= wd1;
        else if (wr_en_i[0] && wa0 == AW'(n)) regs_q[n] <= wd0;
      end
    end
  end

  // Combinational read ports, with optional same-cycle forwarding.
  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;
    ra        = '0;
    rv        = '0;
    rd_data_o = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr_i[k*AW +: AW];
      rv = regs_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (rst && ra != '0) begin
        if (wr_en_i[0] && wa0 == ra) rv = wd0;
        if (wr_en_i[1] && wa1 == ra) rv = wd1;
      end
`endif
      rd_data_o[k*XLEN +: XLEN] = rv;
    end
  end

  // One-cycle delayed copy of the read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data_q_o <= '0;
    else      rd_data_q_o <= rd_data_o;
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .sb_set  (sb_set_i),
    .sb_addr (sb_addr_i),
    .wr_en   (wr_en_i),
    .wr_addr (wr_addr_i),
    .rd_addr (rd_addr_i),
    .busy    (busy_o),
    .rd_busy (rd_busy_o)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp at default geometry (32 x 32, 2 read ports).
// Honours REGFILE_BYPASS_EN for the forwarding expectations.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [63:0] rd_data_q;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic [31:0] busy;

  regfile_mp dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_data_q_o (rd_data_q),
    .rd_busy_o   (rd_busy),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .sb_set_i    (sb_set),
    .sb_addr_i   (sb_addr),
    .busy_o      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model and scoreboard ----------------
  logic [31:0] m_reg [32];
  logic [31:0] m_busy;
  logic [63:0] exp_q [$];
  int          total;
  int          bad;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!rst || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en[1] && wr_addr[9:5] == a) return wr_data[63:32];
    if (wr_en[0] && wr_addr[4:0] == a) return wr_data[31:0];
`endif
    return m_reg[a];
  endfunction

  function automatic logic exp_rb(input logic [4:0] a);
    if (!rst || a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if ((wr_en[1] && wr_addr[9:5] == a) || (wr_en[0] && wr_addr[4:0] == a))
      return sb_set && (sb_addr == a);
`endif
    return m_busy[a];
  endfunction

  task automatic model_update();
    for (int n = 1; n < 32; n++) begin
      if (wr_en[1] && wr_addr[9:5] == 5'(n))      m_reg[n] = wr_data[63:32];
      else if (wr_en[0] && wr_addr[4:0] == 5'(n)) m_reg[n] = wr_data[31:0];
      if ((wr_en[1] && wr_addr[9:5] == 5'(n)) || (wr_en[0] && wr_addr[4:0] == 5'(n)))
        m_busy[n] = 1'b0;
      if (sb_set && sb_addr == 5'(n)) m_busy[n] = 1'b1;
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < 32; n++) m_reg[n] = '0;
    m_busy = '0;
  endtask

  // ---------------- driver tasks ----------------
  function automatic wr_port_t wp(input logic en, input logic [4:0] a, input logic [31:0] d);
    wr_port_t p;
    p.en = en; p.addr = a; p.data = d;
    return p;
  endfunction

  task automatic drive(input wr_port_t p0, input wr_port_t p1, input logic s,
                       input logic [4:0] sa, input logic [4:0] r0, input logic [4:0] r1);
    wr_en   = {p1.en, p0.en};
    wr_addr = {p1.addr, p0.addr};
    wr_data = {p1.data, p0.data};
    sb_set  = s;
    sb_addr = sa;
    rd_addr = {r1, r0};
  endtask

  // Check combinational outputs, push expected read data, clock once,
  // then pop and compare the registered copy and the busy vector.
  task automatic tick();
    logic [63:0] e;
    #1;
    e = {exp_rd(rd_addr[9:5]), exp_rd(rd_addr[4:0])};
    check("rd_data", rd_data, e);
    check("rd_busy", {62'd0, rd_busy}, {62'd0, exp_rb(rd_addr[9:5]), exp_rb(rd_addr[4:0])});
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) model_update();
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL rd_data_q no expected entry t=%0t", $time);
    end else begin
      check("rd_data_q", rd_data_q, exp_q.pop_front());
    end
    check("busy", {32'd0, busy}, {32'd0, m_busy});
  endtask

  typedef struct {
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } rvec_t;

  rvec_t    tbl [32];
  wr_port_t nop;
  wr_port_t p0;
  wr_port_t p1;

  // ---------------- stimulus ----------------
  initial begin
    total = 0;
    bad   = 0;
    nop   = '0;
    model_clear();
    for (int i = 0; i < 32; i++) begin
      tbl[i].ra0 = 5'(i);
      tbl[i].ra1 = 5'((2 * i) % 32);
      tbl[i].e0  = 32'(i);
      tbl[i].e1  = 32'((2 * i) % 32);
    end

    // Reset held 3 cycles; a write and a set presented meanwhile are dropped.
    rst = 1'b0;
    drive(wp(1'b1, 5'd3, 32'hDEAD), nop, 1'b1, 5'd3, 5'd3, 5'd0);
    tick();
    drive(nop, nop, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    rst = 1'b1;

    // All 32 addresses read zero after reset.
    for (int i = 0; i < 32; i++) begin
      drive(nop, nop, 1'b0, 5'd0, 5'(i), 5'(31 - i));
      tick();
    end
    check("rst_busy", {32'd0, busy}, 64'd0);

    // Port 0 writes addr i with data i.
    for (int i = 0; i < 32; i++) begin
      drive(wp(1'b1, 5'(i), 32'(i)), nop, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
    end

    // Table-driven reads: port 0 addr i, port 1 addr 2i mod 32, data = addr.
    for (int i = 0; i < 32; i++) begin
      drive(nop, nop, 1'b0, 5'd0, tbl[i].ra0, tbl[i].ra1);
      #1;
      check("tbl_rd0", {32'd0, rd_data[31:0]}, {32'd0, tbl[i].e0});
      check("tbl_rd1", {32'd0, rd_data[63:32]}, {32'd0, tbl[i].e1});
      tick();
    end

    // Both ports write reg 5 in one cycle: port 1 data stored.
    drive(wp(1'b1, 5'd5, 32'hAAAA), wp(1'b1, 5'd5, 32'h5555), 1'b0, 5'd0, 5'd5, 5'd5);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("dual_wr_fwd", {32'd0, rd_data[31:0]}, 64'h5555);
`else
    check("dual_wr_old", {32'd0, rd_data[31:0]}, 64'h5);
`endif
    tick();
    drive(nop, nop, 1'b0, 5'd0, 5'd5, 5'd5);
    #1;
    check("dual_wr_new", rd_data, {32'h5555, 32'h5555});
    tick();

    // Set reg 7 busy, write it two cycles later.
    drive(nop, nop, 1'b1, 5'd7, 5'd7, 5'd0);
    tick();
    check("busy7_a", {63'd0, busy[7]}, 64'd1);
    drive(nop, nop, 1'b0, 5'd0, 5'd7, 5'd0);
    tick();
    check("busy7_b", {63'd0, busy[7]}, 64'd1);
    drive(wp(1'b1, 5'd7, 32'h77), nop, 1'b0, 5'd0, 5'd7, 5'd0);
    tick();
    check("busy7_c", {63'd0, busy[7]}, 64'd0);

    // Set and write reg 9 together: set wins.
    drive(nop, wp(1'b1, 5'd9, 32'h99), 1'b1, 5'd9, 5'd9, 5'd0);
    tick();
    check("busy9", {63'd0, busy[9]}, 64'd1);

    // Register 0: set and write both ignored.
    drive(wp(1'b1, 5'd0, 32'hFFFF), nop, 1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    check("x0_same", {32'd0, rd_data[31:0]}, 64'd0);
    tick();
    check("busy0", {63'd0, busy[0]}, 64'd0);
    drive(nop, nop, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check("x0_read", rd_data, 64'd0);
    tick();

    // Mid-sequence asynchronous reset after writes to regs 3 and 4.
    drive(wp(1'b1, 5'd3, 32'h33), nop, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(wp(1'b1, 5'd4, 32'h44), nop, 1'b1, 5'd6, 5'd3, 5'd4);
    tick();
    drive(nop, nop, 1'b0, 5'd0, 5'd3, 5'd4);
    tick();
    check("pre_rst_q", rd_data_q, {32'h44, 32'h33});
    rst = 1'b0;
    #1;
    check("arst_rd", rd_data, 64'd0);
    check("arst_rd_q", rd_data_q, 64'd0);
    check("arst_busy", {32'd0, busy}, 64'd0);
    model_clear();
    tick();
    rst = 1'b1;
    drive(nop, nop, 1'b0, 5'd0, 5'd3, 5'd4);
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 300; c++) begin
      p0 = wp(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      p1 = wp(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 3) == 0) p1.addr = p0.addr;
      drive(p0, p1, 1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? p0.addr : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? p1.addr : 5'($urandom_range(0, 31)));
      tick();
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
